// File: rtl/gerenciador_atributos.sv
`default_nettype none
// ============================================================================
// gerenciador_atributos : step-timed decay/recovery of fome, felicidade, sono
// Rev 1.0
// ============================================================================
module gerenciador_atributos #(
    parameter int         PASSO_CICLOS  = 50_000_000,
    parameter logic [7:0] GANHO         = 8'd16,
    parameter logic [7:0] VALOR_INICIAL = 8'd200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] estado,
    output logic [7:0] fome,
    output logic [7:0] felicidade,
    output logic [7:0] sono,
    output logic       passo
);

    localparam int          c_CW      = (PASSO_CICLOS > 1) ? $clog2(PASSO_CICLOS) : 1;
    localparam logic [c_CW-1:0] c_ULTIMO = c_CW'(PASSO_CICLOS - 1);

    localparam logic [3:0] c_IDLE       = 4'b0000;
    localparam logic [3:0] c_DORMINDO   = 4'b0001;
    localparam logic [3:0] c_COMENDO    = 4'b0010;
    localparam logic [3:0] c_DANDO_AULA = 4'b0100;
    localparam logic [3:0] c_MORTO      = 4'b1000;

    logic [c_CW-1:0] cont_q, cont_d;
    logic [7:0]      fome_q, fome_d;
    logic [7:0]      feli_q, feli_d;
    logic [7:0]      sono_q, sono_d;
    logic            passo_q;
    logic            w_step;
    logic            w_congelado;

    function automatic logic [7:0] f_somar(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Borrow out of the 9-bit difference means the true result is negative.
    function automatic logic [7:0] f_subtrair(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[8] ? 8'h00 : d[7:0];
    endfunction

    assign w_step      = (cont_q == c_ULTIMO);
    assign w_congelado = (fome_q == 8'd0) || (feli_q == 8'd0) || (sono_q == 8'd0);

    always_comb begin
        cont_d = w_step ? '0 : cont_q + 1'b1;
    end

    always_comb begin
        fome_d = fome_q;
        feli_d = feli_q;
        sono_d = sono_q;
        if (w_step && !w_congelado) begin
            case (estado)
                c_MORTO: begin
                end
                c_COMENDO: begin
                    fome_d = f_somar(fome_q, GANHO);
                    sono_d = f_subtrair(sono_q, 8'd1);
                    feli_d = f_subtrair(feli_q, 8'd1);
                end
                c_DORMINDO: begin
                    sono_d = f_somar(sono_q, GANHO);
                    fome_d = f_subtrair(fome_q, 8'd1);
                end
                c_DANDO_AULA: begin
                    feli_d = f_somar(feli_q, GANHO);
                    fome_d = f_subtrair(fome_q, 8'd2);
                    sono_d = f_subtrair(sono_q, 8'd2);
                end
                c_IDLE: begin
                    fome_d = f_subtrair(fome_q, 8'd1);
                    sono_d = f_subtrair(sono_q, 8'd1);
                    feli_d = f_subtrair(feli_q, 8'd1);
                end
                default: begin
                    fome_d = f_subtrair(fome_q, 8'd1);
                    sono_d = f_subtrair(sono_q, 8'd1);
                    feli_d = f_subtrair(feli_q, 8'd1);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cont_q  <= '0;
            fome_q  <= VALOR_INICIAL;
            feli_q  <= VALOR_INICIAL;
            sono_q  <= VALOR_INICIAL;
            passo_q <= 1'b0;
        end else begin
            cont_q  <= cont_d;
            fome_q  <= fome_d;
            feli_q  <= feli_d;
            sono_q  <= sono_d;
            passo_q <= w_step;
        end
    end

    assign fome       = fome_q;
    assign felicidade = feli_q;
    assign sono       = sono_q;
    assign passo      = passo_q;

endmodule
`default_nettype wire

// File: tb/tb_gerenciador_atributos.sv
`default_nettype none
// ============================================================================
// tb_gerenciador_atributos : directed self-checking bench for gerenciador_atributos
// Rev 1.0
// ============================================================================
module tb_gerenciador_atributos;

    localparam logic [3:0] IDLE       = 4'b0000;
    localparam logic [3:0] DORMINDO   = 4'b0001;
    localparam logic [3:0] COMENDO    = 4'b0010;
    localparam logic [3:0] DANDO_AULA = 4'b0100;
    localparam logic [3:0] MORTO      = 4'b1000;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] estado;
    logic [3:0] estado_sat = COMENDO;
    logic [3:0] estado_p1  = IDLE;
    logic [7:0] fome, felicidade, sono;
    logic       passo;
    logic [7:0] fome_s, feli_s, sono_s;
    logic       passo_s;
    logic [7:0] fome_1, feli_1, sono_1;
    logic       passo_1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gerenciador_atributos #(.PASSO_CICLOS(4), .GANHO(8'd8), .VALOR_INICIAL(8'd10)) u_dut (
        .clk(clk), .rst(rst), .estado(estado),
        .fome(fome), .felicidade(felicidade), .sono(sono), .passo(passo)
    );

    gerenciador_atributos #(.PASSO_CICLOS(4), .GANHO(8'd8), .VALOR_INICIAL(8'd250)) u_sat (
        .clk(clk), .rst(rst), .estado(estado_sat),
        .fome(fome_s), .felicidade(feli_s), .sono(sono_s), .passo(passo_s)
    );

    gerenciador_atributos #(.PASSO_CICLOS(1), .GANHO(8'd8), .VALOR_INICIAL(8'd10)) u_p1 (
        .clk(clk), .rst(rst), .estado(estado_p1),
        .fome(fome_1), .felicidade(feli_1), .sono(sono_1), .passo(passo_1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_attr(input string tag, input logic [7:0] f, input logic [7:0] fe, input logic [7:0] s);
        chk({tag, ".fome"}, 32'(fome), 32'(f));
        chk({tag, ".felicidade"}, 32'(felicidade), 32'(fe));
        chk({tag, ".sono"}, 32'(sono), 32'(s));
    endtask

    // Returns the number of cycles until passo is seen high (bounded).
    task automatic aguardar_passo(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!passo && n < 16);
    endtask

    task automatic aplicar_reset(input string tag);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_attr(tag, 8'd10, 8'd10, 8'd10);
        chk({tag, ".passo"}, 32'(passo), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int pulsos;
        rst    = 1'b1;
        estado = IDLE;

        // Reset state of all three instances, then IDLE for three steps
        aplicar_reset("reset");
        chk("sat.reset", 32'(fome_s), 32'd250);
        chk("p1.reset.passo", 32'(passo_1), 32'd0);
        chk("p1.reset.fome", 32'(fome_1), 32'd10);
        aguardar_passo(n);
        chk("idle.periodo1", n, 4);
        chk_attr("idle.s1", 8'd9, 8'd9, 8'd9);
        chk("sat.s1.fome", 32'(fome_s), 32'd255);
        chk("sat.s1.sono", 32'(sono_s), 32'd249);
        chk("sat.s1.felicidade", 32'(feli_s), 32'd249);
        chk("p1.s1.fome", 32'(fome_1), 32'd6);
        chk("p1.s1.passo", 32'(passo_1), 32'd1);
        aguardar_passo(n);
        chk("idle.periodo2", n, 4);
        chk_attr("idle.s2", 8'd8, 8'd8, 8'd8);
        aguardar_passo(n);
        chk("idle.periodo3", n, 4);
        chk_attr("idle.s3", 8'd7, 8'd7, 8'd7);
        chk("sat.s3.fome", 32'(fome_s), 32'd255);
        chk("sat.s3.sono", 32'(sono_s), 32'd247);
        chk("p1.s3.fome", 32'(fome_1), 32'd0);
        chk("p1.s3.sono", 32'(sono_1), 32'd0);
        chk("p1.s3.felicidade", 32'(feli_1), 32'd0);

        // Drive sono to 1 then to the 0 clamp with DANDO_AULA, then frozen
        estado = IDLE;
        aplicar_reset("reset2");
        aguardar_passo(n);
        chk_attr("clamp.pre", 8'd9, 8'd9, 8'd9);
        estado = DANDO_AULA;
        repeat (4) aguardar_passo(n);
        chk_attr("aula.s4", 8'd1, 8'd41, 8'd1);
        aguardar_passo(n);
        chk_attr("aula.clamp", 8'd0, 8'd49, 8'd0);
        aguardar_passo(n);
        chk("freeze.periodo", n, 4);
        chk_attr("freeze.aula", 8'd0, 8'd49, 8'd0);
        estado = IDLE;
        aguardar_passo(n);
        chk_attr("freeze.idle", 8'd0, 8'd49, 8'd0);
        estado = COMENDO;
        aguardar_passo(n);
        chk("freeze.comendo.periodo", n, 4);
        chk_attr("freeze.comendo", 8'd0, 8'd49, 8'd0);

        // DORMINDO for two steps from reset
        estado = DORMINDO;
        aplicar_reset("reset3");
        aguardar_passo(n);
        chk_attr("dorm.s1", 8'd9, 8'd10, 8'd18);
        aguardar_passo(n);
        chk_attr("dorm.s2", 8'd8, 8'd10, 8'd26);

        // Reset two cycles into a period, then MORTO for five steps
        repeat (2) @(negedge clk);
        estado = MORTO;
        rst    = 1'b1;
        @(negedge clk);
        chk_attr("midreset", 8'd10, 8'd10, 8'd10);
        chk("midreset.passo", 32'(passo), 32'd0);
        rst = 1'b0;
        pulsos = 0;
        for (int i = 0; i < 5; i++) begin
            aguardar_passo(n);
            if (passo) pulsos++;
            chk("morto.periodo", n, 4);
        end
        chk("morto.pulsos", pulsos, 5);
        chk_attr("morto.hold", 8'd10, 8'd10, 8'd10);

        // estado changes right after the step edge: old value governs
        estado = IDLE;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 estado = COMENDO;
        @(negedge clk);
        chk("coinc.passo", 32'(passo), 32'd1);
        chk_attr("coinc.old", 8'd9, 8'd9, 8'd9);
        aguardar_passo(n);
        chk("coinc.periodo", n, 4);
        chk_attr("coinc.new", 8'd17, 8'd8, 8'd8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
